// File: rtl/axis_frame_fifo_if.sv
// -----------------------------------------------------------------------------
// axis_frame_fifo_if
// AXI-stream bundle used on both sides of axis_frame_fifo.
//   tdata  : payload word
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : last beat of a frame
//   tuser  : sideband; bit 0 marks a bad frame on the tlast beat
// Modports: master drives the stream, slave receives it.
// -----------------------------------------------------------------------------
interface axis_frame_fifo_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned USER_W = 1
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [USER_W-1:0] tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_fifo.sv
// -----------------------------------------------------------------------------
// axis_frame_fifo
// AXI-stream FIFO with optional frame mode: words become readable only once
// their frame's tlast is accepted, so partial or flagged frames never leave.
// Ports:
//   i_clk, i_rst             : clock, synchronous active-high reset
//   s_axis (slave)           : input stream (tdata, tvalid, tready, tlast, tuser[0])
//   m_axis (master)          : output stream (tdata, tvalid, tlast; tuser = 0)
//   o_status_depth           : accepted words not yet read (incl. uncommitted)
//   o_status_depth_commit    : committed words not yet read
//   o_status_almost_full     : o_status_depth >= AFULL_LEVEL
//   o_status_almost_empty    : o_status_depth_commit <= AEMPTY_LEVEL
//   o_status_overflow        : pulse, beat/frame discarded for lack of space
//   o_status_bad_frame       : pulse, frame discarded because of tuser[0]
//   o_status_good_frame      : pulse, frame committed (frame mode)
// -----------------------------------------------------------------------------
module axis_frame_fifo #(
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned DATA_W         = 8,
   parameter bit          FRAME_FIFO     = 1'b1,
   parameter bit          DROP_OVERSIZE  = 1'b1,
   parameter bit          DROP_BAD_FRAME = 1'b1,
   parameter bit          DROP_WHEN_FULL = 1'b0,
   parameter int unsigned AFULL_LEVEL    = DEPTH - 2,
   parameter int unsigned AEMPTY_LEVEL   = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   axis_frame_fifo_if.slave        s_axis,
   axis_frame_fifo_if.master       m_axis,
   output logic [$clog2(DEPTH):0]  o_status_depth,
   output logic [$clog2(DEPTH):0]  o_status_depth_commit,
   output logic                    o_status_almost_full,
   output logic                    o_status_almost_empty,
   output logic                    o_status_overflow,
   output logic                    o_status_bad_frame,
   output logic                    o_status_good_frame
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {StIdle, StWrite, StDrop} state_e;

   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic              r_mem_last [DEPTH];

   // r_fetch_ptr moves when a word enters the output register; r_rd_ptr moves
   // on the output handshake, so the output register counts toward occupancy.
   logic [PW-1:0]     r_wr_ptr, r_commit_ptr, r_fetch_ptr, r_rd_ptr;
   state_e            r_state;
   logic              r_s_ready;
   logic              r_out_valid, r_out_last;
   logic [DATA_W-1:0] r_out_data;
   logic [PW-1:0]     r_depth, r_depth_commit;
   logic              r_afull, r_aempty, r_overflow, r_bad, r_good;

   logic          w_s_hs, w_m_hs, w_full, w_load, w_store;
   logic          w_ovf, w_bad, w_good, w_full_d, w_oversize_d, w_ready_d;
   logic [PW-1:0] w_wr_d, w_commit_d, w_fetch_d, w_rd_d, w_depth_d, w_depth_commit_d;
   state_e        w_state_d;

   assign w_s_hs = s_axis.tvalid && r_s_ready;
   assign w_m_hs = r_out_valid && m_axis.tready;
   assign w_full = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
   assign w_load = (!r_out_valid || m_axis.tready) && (r_commit_ptr != r_fetch_ptr);

   always_comb begin
      w_wr_d     = r_wr_ptr;
      w_commit_d = r_commit_ptr;
      w_state_d  = r_state;
      w_store    = 1'b0;
      w_ovf      = 1'b0;
      w_bad      = 1'b0;
      w_good     = 1'b0;
      if (w_s_hs) begin
         if (FRAME_FIFO) begin
            if (r_state == StDrop) begin
               if (s_axis.tlast) w_state_d = StIdle;
            end else if (w_full) begin
               // Only reachable via DROP_WHEN_FULL or an oversize frame: the
               // whole frame goes, including anything stored so far.
               w_wr_d    = r_commit_ptr;
               w_ovf     = 1'b1;
               w_state_d = s_axis.tlast ? StIdle : StDrop;
            end else begin
               w_store = 1'b1;
               w_wr_d  = r_wr_ptr + 1'b1;
               if (s_axis.tlast) begin
                  w_state_d = StIdle;
                  if (s_axis.tuser[0] && DROP_BAD_FRAME) begin
                     w_wr_d = r_commit_ptr;
                     w_bad  = 1'b1;
                  end else begin
                     w_commit_d = r_wr_ptr + 1'b1;
                     w_good     = 1'b1;
                  end
               end else begin
                  w_state_d = StWrite;
               end
            end
         end else if (w_full) begin
            w_ovf = 1'b1;
         end else begin
            w_store    = 1'b1;
            w_wr_d     = r_wr_ptr + 1'b1;
            w_commit_d = r_wr_ptr + 1'b1;
         end
      end
   end

   assign w_fetch_d        = r_fetch_ptr + {{(PW-1){1'b0}}, w_load};
   assign w_rd_d           = r_rd_ptr + {{(PW-1){1'b0}}, w_m_hs};
   assign w_depth_d        = w_wr_d - w_rd_d;
   assign w_depth_commit_d = w_commit_d - w_rd_d;
   assign w_full_d         = w_depth_d == PW'(DEPTH);
   // A frame filling the whole buffer must still be allowed one more beat so
   // it can be recognised as oversize and dropped instead of deadlocking.
   assign w_oversize_d     = FRAME_FIFO && DROP_OVERSIZE
                             && ((w_wr_d - w_commit_d) == PW'(DEPTH));
   assign w_ready_d        = !w_full_d || DROP_WHEN_FULL || (w_state_d == StDrop)
                             || w_oversize_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr       <= '0;
         r_commit_ptr   <= '0;
         r_fetch_ptr    <= '0;
         r_rd_ptr       <= '0;
         r_state        <= StIdle;
         r_s_ready      <= 1'b0;
         r_out_valid    <= 1'b0;
         r_out_data     <= '0;
         r_out_last     <= 1'b0;
         r_depth        <= '0;
         r_depth_commit <= '0;
         r_afull        <= 1'b0;
         r_aempty       <= 1'b1;
         r_overflow     <= 1'b0;
         r_bad          <= 1'b0;
         r_good         <= 1'b0;
      end else begin
         if (w_store) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= s_axis.tdata;
            r_mem_last[r_wr_ptr[AW-1:0]] <= s_axis.tlast;
         end
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem_data[r_fetch_ptr[AW-1:0]];
            r_out_last  <= r_mem_last[r_fetch_ptr[AW-1:0]];
         end else if (m_axis.tready) begin
            r_out_valid <= 1'b0;
         end
         r_wr_ptr       <= w_wr_d;
         r_commit_ptr   <= w_commit_d;
         r_fetch_ptr    <= w_fetch_d;
         r_rd_ptr       <= w_rd_d;
         r_state        <= w_state_d;
         r_s_ready      <= w_ready_d;
         r_depth        <= w_depth_d;
         r_depth_commit <= w_depth_commit_d;
         r_afull        <= 32'(w_depth_d) >= AFULL_LEVEL;
         r_aempty       <= 32'(w_depth_commit_d) <= AEMPTY_LEVEL;
         r_overflow     <= w_ovf;
         r_bad          <= w_bad;
         r_good         <= w_good;
      end
   end

   assign s_axis.tready = r_s_ready;
   assign m_axis.tvalid = r_out_valid;
   assign m_axis.tdata  = r_out_data;
   assign m_axis.tlast  = r_out_last;
   assign m_axis.tuser  = '0;

   assign o_status_depth        = r_depth;
   assign o_status_depth_commit = r_depth_commit;
   assign o_status_almost_full  = r_afull;
   assign o_status_almost_empty = r_aempty;
   assign o_status_overflow     = r_overflow;
   assign o_status_bad_frame    = r_bad;
   assign o_status_good_frame   = r_good;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_fifo
// Directed bench for axis_frame_fifo: one word-mode and one frame-mode
// instance (DEPTH=16) share clock and reset. Inputs change 1 time unit after
// the rising edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_frame_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axis_frame_fifo_if #(.DATA_W(8)) sw_if ();
   axis_frame_fifo_if #(.DATA_W(8)) mw_if ();
   axis_frame_fifo_if #(.DATA_W(8)) sf_if ();
   axis_frame_fifo_if #(.DATA_W(8)) mf_if ();

   logic [4:0] w_depth, w_depthc, f_depth, f_depthc;
   logic       w_afull, w_aempty, w_ovf, w_bad, w_good;
   logic       f_afull, f_aempty, f_ovf, f_bad, f_good;

   axis_frame_fifo #(.DEPTH(16), .DATA_W(8), .FRAME_FIFO(1'b0)) u_dut_word (
      .i_clk                 (clk),
      .i_rst                 (rst),
      .s_axis                (sw_if),
      .m_axis                (mw_if),
      .o_status_depth        (w_depth),
      .o_status_depth_commit (w_depthc),
      .o_status_almost_full  (w_afull),
      .o_status_almost_empty (w_aempty),
      .o_status_overflow     (w_ovf),
      .o_status_bad_frame    (w_bad),
      .o_status_good_frame   (w_good)
   );

   axis_frame_fifo #(.DEPTH(16), .DATA_W(8), .FRAME_FIFO(1'b1)) u_dut_frame (
      .i_clk                 (clk),
      .i_rst                 (rst),
      .s_axis                (sf_if),
      .m_axis                (mf_if),
      .o_status_depth        (f_depth),
      .o_status_depth_commit (f_depthc),
      .o_status_almost_full  (f_afull),
      .o_status_almost_empty (f_aempty),
      .o_status_overflow     (f_ovf),
      .o_status_bad_frame    (f_bad),
      .o_status_good_frame   (f_good)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_cnt  = 0;
   int n_f_good = 0, n_f_bad = 0, n_f_ovf = 0;
   int n_w_good = 0, n_w_bad = 0, n_w_ovf = 0;
   int max_w_depth = 0;
   logic [8:0] q_w [$];
   logic [8:0] q_f [$];
   int         q_fc [$];
   bit         stop_rand = 1'b0;

   always @(negedge clk) begin
      cyc_cnt++;
      if (mw_if.tvalid && mw_if.tready) q_w.push_back({mw_if.tlast, mw_if.tdata});
      if (mf_if.tvalid && mf_if.tready) begin
         q_f.push_back({mf_if.tlast, mf_if.tdata});
         q_fc.push_back(cyc_cnt);
      end
      if (f_good) n_f_good++;
      if (f_bad)  n_f_bad++;
      if (f_ovf)  n_f_ovf++;
      if (w_good) n_w_good++;
      if (w_bad)  n_w_bad++;
      if (w_ovf)  n_w_ovf++;
      if (int'(w_depth) > max_w_depth) max_w_depth = int'(w_depth);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one beat and wait (bounded) until it is accepted.
   task automatic push(input bit word, input logic [7:0] d, input logic l, input logic u,
                       input string tag);
      bit acc = 1'b0;
      int n   = 0;
      if (word) begin
         sw_if.tvalid = 1'b1; sw_if.tdata = d; sw_if.tlast = l; sw_if.tuser = u;
      end else begin
         sf_if.tvalid = 1'b1; sf_if.tdata = d; sf_if.tlast = l; sf_if.tuser = u;
      end
      while (!acc && n < 200) begin
         acc = word ? sw_if.tready : sf_if.tready;
         cyc(1);
         n++;
      end
      if (word) sw_if.tvalid = 1'b0;
      else      sf_if.tvalid = 1'b0;
      if (!acc) check({tag, "_accept_timeout"}, 32'(acc), 32'd1);
   endtask

   task automatic wait_q(input bit word, input int k, input int budget);
      int n = 0;
      while ((word ? q_w.size() : q_f.size()) < k && n < budget) begin
         cyc(1);
         n++;
      end
   endtask

   initial begin
      int errs;
      int g0, b0, o0;
      sw_if.tvalid = 0; sw_if.tdata = 0; sw_if.tlast = 0; sw_if.tuser = 0;
      sf_if.tvalid = 0; sf_if.tdata = 0; sf_if.tlast = 0; sf_if.tuser = 0;
      mw_if.tready = 0; mf_if.tready = 0;

      // Reset state.
      cyc(3);
      check("rst_f_tready", 32'(sf_if.tready), 0);
      check("rst_f_tvalid", 32'(mf_if.tvalid), 0);
      check("rst_f_tdata",  32'(mf_if.tdata), 0);
      check("rst_f_tlast",  32'(mf_if.tlast), 0);
      check("rst_f_depth",  32'(f_depth), 0);
      check("rst_f_depthc", 32'(f_depthc), 0);
      check("rst_f_afull",  32'(f_afull), 0);
      check("rst_f_aempty", 32'(f_aempty), 1);
      check("rst_f_pulses", 32'({f_ovf, f_bad, f_good}), 0);
      check("rst_w_tready", 32'(sw_if.tready), 0);
      check("rst_w_aempty", 32'(w_aempty), 1);
      rst = 1'b0;
      cyc(1);
      check("rst_rel_f_tready", 32'(sf_if.tready), 1);
      check("rst_rel_w_tready", 32'(sw_if.tready), 1);

      // Word mode: fill to full with the reader stalled.
      for (int i = 0; i < 16; i++) push(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, "wfill");
      check("wfull_tready",  32'(sw_if.tready), 0);
      check("wfull_depth",   32'(w_depth), 16);
      check("wfull_depthc",  32'(w_depthc), 16);
      check("wfull_afull",   32'(w_afull), 1);
      check("wfull_tdata",   32'(mw_if.tdata), 32'hA0);
      check("wfull_tuser",   32'(mw_if.tuser), 0);
      mw_if.tready = 1'b1;
      wait_q(1'b1, 16, 100);
      check("wdrain_count", 32'(q_w.size()), 16);
      for (int i = 0; i < 16 && i < q_w.size(); i++)
         check("wdrain_data", 32'(q_w[i]), 32'hA0 + 32'(i));
      cyc(2);
      check("wdrain_depth",  32'(w_depth), 0);
      check("wdrain_aempty", 32'(w_aempty), 1);
      check("wdrain_tready", 32'(sw_if.tready), 1);

      // Word mode latency: valid appears one edge after acceptance.
      mw_if.tready = 1'b0;
      push(1'b1, 8'h5A, 1'b1, 1'b0, "wlat");
      check("wlat_n0_tvalid", 32'(mw_if.tvalid), 0);
      cyc(1);
      check("wlat_n1_tvalid", 32'(mw_if.tvalid), 1);
      check("wlat_n1_word",   32'({mw_if.tlast, mw_if.tdata}), 32'h15A);
      mw_if.tready = 1'b1;
      cyc(2);
      q_w.delete();

      // Frame mode: 5-beat frame held back until tlast, then streamed.
      mf_if.tready = 1'b1;
      g0 = n_f_good;
      q_f.delete(); q_fc.delete();
      for (int i = 0; i < 5; i++) begin
         push(1'b0, 8'h10 + 8'(i), i == 4, 1'b0, "f5");
         check("f5_hold_tvalid", 32'(mf_if.tvalid), 0);
      end
      wait_q(1'b0, 5, 50);
      cyc(2);
      check("f5_count", 32'(q_f.size()), 5);
      for (int i = 0; i < 5 && i < q_f.size(); i++) begin
         check("f5_data", 32'(q_f[i]), (i == 4) ? 32'h114 : 32'h10 + 32'(i));
         check("f5_b2b",  32'(q_fc[i] - q_fc[0]), 32'(i));
      end
      check("f5_good_pulses", 32'(n_f_good - g0), 1);

      // Frame mode: bad frame dropped, good frame after it kept.
      mf_if.tready = 1'b0;
      g0 = n_f_good; b0 = n_f_bad;
      q_f.delete();
      for (int i = 0; i < 4; i++) push(1'b0, 8'h20 + 8'(i), i == 3, i == 3, "fbad");
      push(1'b0, 8'h55, 1'b0, 1'b0, "fgood");
      push(1'b0, 8'h66, 1'b1, 1'b0, "fgood");
      cyc(2);
      check("fbad_depth",  32'(f_depth), 2);
      check("fbad_depthc", 32'(f_depthc), 2);
      check("fbad_pulses", 32'(n_f_bad - b0), 1);
      check("fbad_head",   32'({mf_if.tvalid, mf_if.tdata}), 32'h155);
      mf_if.tready = 1'b1;
      wait_q(1'b0, 2, 50);
      cyc(2);
      check("fbad_count", 32'(q_f.size()), 2);
      if (q_f.size() >= 2) begin
         check("fbad_w0", 32'(q_f[0]), 32'h055);
         check("fbad_w1", 32'(q_f[1]), 32'h166);
      end
      check("fbad_good_pulses", 32'(n_f_good - g0), 1);

      // Frame mode: oversize frame dropped, remaining beats still accepted.
      o0 = n_f_ovf;
      q_f.delete();
      for (int i = 0; i < 20; i++) push(1'b0, 8'h80 + 8'(i), i == 19, 1'b0, "fover");
      for (int i = 0; i < 3; i++) push(1'b0, 8'hC0 + 8'(i), i == 2, 1'b0, "fafter");
      wait_q(1'b0, 3, 50);
      cyc(4);
      check("fover_count", 32'(q_f.size()), 3);
      for (int i = 0; i < 3 && i < q_f.size(); i++)
         check("fover_data", 32'(q_f[i]), (i == 2) ? 32'h1C2 : 32'hC0 + 32'(i));
      check("fover_pulses", 32'(n_f_ovf - o0), 1);
      check("fover_afull",  32'(f_afull), 0);

      // Word mode: 100 beats with random gaps and random back-pressure.
      q_w.delete();
      max_w_depth = 0;
      fork
         begin
            while (!stop_rand) begin
               mw_if.tready = 1'($urandom_range(0, 1));
               cyc(1);
            end
         end
      join_none
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 3) == 0) cyc(1);
         push(1'b1, 8'(i), 1'b0, 1'b0, "wrap");
      end
      wait_q(1'b1, 100, 600);
      stop_rand = 1'b1;
      cyc(2);
      mw_if.tready = 1'b1;
      cyc(2);
      check("wrap_count", 32'(q_w.size()), 100);
      errs = 0;
      for (int i = 0; i < q_w.size(); i++) if (q_w[i] !== {1'b0, 8'(i)}) errs++;
      check("wrap_order_errs", 32'(errs), 0);
      check("wrap_max_depth_ok", 32'(max_w_depth <= 16), 1);
      check("wrap_no_ovf", 32'(n_w_ovf), 0);
      check("word_no_frame_pulses", 32'(n_w_good + n_w_bad), 0);

      // Reset mid-frame with a committed word sitting in the output register.
      mf_if.tready = 1'b0;
      push(1'b0, 8'h77, 1'b1, 1'b0, "frst_pre");
      for (int i = 0; i < 3; i++) push(1'b0, 8'hE0 + 8'(i), 1'b0, 1'b0, "frst_part");
      cyc(1);
      check("frst_pre_tvalid", 32'(mf_if.tvalid), 1);
      rst = 1'b1;
      cyc(1);
      check("frst_tready", 32'(sf_if.tready), 0);
      check("frst_out",    32'({mf_if.tvalid, mf_if.tlast, mf_if.tdata}), 0);
      check("frst_depth",  32'({f_depth, f_depthc}), 0);
      check("frst_flags",  32'({f_afull, f_aempty, f_ovf, f_bad, f_good}), 32'b01000);
      rst = 1'b0;
      cyc(1);
      q_f.delete();
      mf_if.tready = 1'b1;
      for (int i = 0; i < 4; i++) push(1'b0, 8'hD0 + 8'(i), i == 3, 1'b0, "fpost");
      wait_q(1'b0, 4, 50);
      cyc(4);
      check("fpost_count", 32'(q_f.size()), 4);
      for (int i = 0; i < 4 && i < q_f.size(); i++)
         check("fpost_data", 32'(q_f[i]), (i == 3) ? 32'h1D3 : 32'hD0 + 32'(i));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_frame_fifo.md
# axis_frame_fifo

Parametrised AXI-stream FIFO with optional frame (packet) mode, frame dropping and extended status. It replaces the plain word FIFO on AXI-stream paths that must never forward a partial or corrupted frame, such as UART receive into the AES core and AES output back to UART. Storage is a DEPTH-entry circular buffer with separate write, commit and read pointers.

## Interface

- Parameters
  - DEPTH, 16: total capacity in words; power of two, at least 4.
  - DATA_W, 8: tdata width.
  - FRAME_FIFO, 1: 1 means words are visible on m_axis only after their frame's tlast is accepted; 0 is plain word FIFO.
  - DROP_OVERSIZE, 1: frame mode only; discard a frame longer than DEPTH instead of deadlocking.
  - DROP_BAD_FRAME, 1: frame mode only; discard a frame whose tlast beat carries tuser[0]=1.
  - DROP_WHEN_FULL, 0: hold s_axis.tready high and discard beats when full, instead of back-pressuring.
  - AFULL_LEVEL, DEPTH-2: almost-full threshold.
  - AEMPTY_LEVEL, 2: almost-empty threshold.
- Ports
  - Clk  in  1  the single clock.
  - Rst  in  1  synchronous, active-high reset.
  - s_axis  taxi_axis_if sink  DATA_W  input stream; uses tdata, tvalid, tready, tlast and tuser[0].
  - m_axis  taxi_axis_if source  DATA_W  output stream; drives tdata, tvalid and tlast; tuser is driven 0.
  - StatusDepth  out  $clog2(DEPTH)+1  words accepted and not yet read, including uncommitted words.
  - StatusDepthCommit  out  $clog2(DEPTH)+1  committed (readable) words not yet read.
  - StatusAlmostFull  out  1  StatusDepth >= AFULL_LEVEL.
  - StatusAlmostEmpty  out  1  StatusDepthCommit <= AEMPTY_LEVEL.
  - StatusOverflow  out  1  one-cycle pulse when a beat or frame is discarded for lack of space.
  - StatusBadFrame  out  1  one-cycle pulse when a frame is discarded because of tuser[0].
  - StatusGoodFrame  out  1  one-cycle pulse when a frame commits (frame mode only).

## Operation

- Pointers
  - Write, commit and read pointers are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Full: write − read == DEPTH. Empty for reading: commit == read.
  - All arithmetic is modulo 2^($clog2(DEPTH)+1).
- Word mode (FRAME_FIFO=0): the commit pointer follows the write pointer on every accepted beat; tlast is stored and forwarded.
- Frame mode (FRAME_FIFO=1): write state machine with states IDLE, WRITE and DROP.
  - IDLE→WRITE on the first accepted beat.
  - WRITE: tlast with tuser[0]=0 advances commit to the write pointer, pulses StatusGoodFrame, then goes to IDLE.
  - WRITE: tlast with tuser[0]=1 and DROP_BAD_FRAME set rolls the write pointer back to commit and pulses StatusBadFrame.
  - WRITE→DROP when write − commit == DEPTH and another beat arrives without tlast, if DROP_OVERSIZE is set. The write pointer rolls back to commit and StatusOverflow pulses.
  - WRITE→DROP when a beat arrives while full, if DROP_WHEN_FULL is set (same rollback and pulse).
  - DROP: s_axis.tready=1 and all beats are discarded; return to IDLE after the tlast beat.
- s_axis.tready = !full || DROP_WHEN_FULL || state==DROP. It is derived from registered state only, with no combinational path from m_axis.tready.
- Word mode with DROP_WHEN_FULL: each discarded beat pulses StatusOverflow.
- Output stage
  - One output register: it loads the word at the read pointer whenever it is empty, or is being emptied, and commit != read.
  - m_axis.tvalid stays high until the handshake; tdata and tlast are stable while tvalid=1 and tready=0.
- Status outputs are registered.

## Timing

- Reset
  - While Rst is high and on the cycle it is sampled: all pointers 0, state IDLE, s_axis.tready=0, m_axis.tvalid=0, m_axis.tdata=0, m_axis.tlast=0.
  - StatusDepth=0, StatusDepthCommit=0, StatusAlmostFull=0, StatusAlmostEmpty=1, all pulses 0.
  - s_axis.tready rises the first cycle after Rst is low.
- Reset mid-frame discards the partial frame and the output-register contents.
- Latency
  - Word mode: a beat accepted at edge N gives m_axis.tvalid=1 after edge N+1.
  - Frame mode: the first word is valid after edge N+1, where N is the tlast acceptance edge.
- Throughput: one beat per cycle sustained when both sides are ready, including across pointer wrap-around.
- Full with a simultaneous read: tready stays 0 that cycle and rises the next cycle.
- Status: StatusDepth and StatusDepthCommit update one cycle after the handshake that changes them. A simultaneous read and write leaves StatusDepth unchanged.
- Pulses are high for exactly one cycle, after the triggering edge.

## Test plan

- Word mode, DEPTH=16: write 0xA0..0xAF with m_axis.tready=0 → s_axis.tready=0 after the 16th beat; StatusDepth=16; StatusAlmostFull=1. Then read → 0xA0..0xAF in order; StatusDepth returns to 0.
- Frame mode: send a 5-beat frame 0x10..0x14 with m_axis.tready=1 → m_axis.tvalid stays 0 until the cycle after tlast; then 5 back-to-back beats with tlast on 0x14; StatusGoodFrame pulses once.
- Frame mode: a 4-beat frame with tuser[0]=1 on tlast, then a 2-beat good frame 0x55,0x66 → only 0x55,0x66 appear; StatusBadFrame pulses once; StatusDepth=2 before reading.
- Frame mode: a 20-beat frame into DEPTH=16, then a 3-beat frame → the first frame is dropped, its remaining beats are accepted with tready=1, StatusOverflow pulses once; only the 3-beat frame is output.
- Sustained wrap: 100 beats with random tvalid/tready → in-order, lossless output; StatusDepth never exceeds 16.
- Assert Rst for 1 cycle mid-frame after 3 beats → all outputs at reset values; the next complete frame passes unaltered.
